line_sender: RTL and testbench
==============================

LINE_SENDER -- requirements
Module: line_sender

Interface
REQ-001: The block SHALL have parameter WORD_SIZE, default 32, as the width of the line word.
REQ-002: The block SHALL have parameter SIZE_WORD, default 3, as the width of the byte-count field.
REQ-003: The block SHALL have parameter DATA_WIDTH, default 8, as the bits per UART character.
REQ-004: The block SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per UART bit; legal range is 2 or more.
REQ-005: Port clk SHALL be an input, 1 bit wide, the clock; all logic is rising-edge triggered.
REQ-006: Port rst SHALL be an input, 1 bit wide, the reset; synchronous, active-high.
REQ-007: Port send_data_register SHALL be an input, WORD_SIZE bits wide, the line to transmit; byte 0 is [7:0].
REQ-008: Port size_line SHALL be an input, SIZE_WORD bits wide, the number of bytes to transmit.
REQ-009: Port valid_data SHALL be an input, 1 bit wide, the request strobe from the controller.
REQ-010: Port busy_sender_data SHALL be an output, 1 bit wide, high while a line is in flight.
REQ-011: Port tx SHALL be an output, 1 bit wide, the UART serial line, 8N1, idle high.
REQ-012: Port line_done SHALL be an output, 1 bit wide, a one-cycle pulse when the last stop bit completes.

Function
REQ-013: The FSM SHALL have states IDLE, START, DATA and STOP; busy_sender_data SHALL be 1 in every state except IDLE.
REQ-014: An internal flag armed SHALL be set in any cycle where valid_data=0 and SHALL be cleared on acceptance.
- Purpose: a level held high by the controller produces exactly one transmission.
REQ-015: Acceptance SHALL occur at an edge where state=IDLE, valid_data=1, armed=1 and size_line!=0.
- At acceptance: latch send_data_register and size_line, clear the byte index, and go to START.
REQ-016: If size_line=0 at that edge, the request SHALL be dropped: no transmission, armed cleared, busy_sender_data stays 0.
REQ-017: If size_line exceeds WORD_SIZE/DATA_WIDTH, it SHALL be clamped to WORD_SIZE/DATA_WIDTH (4).
REQ-018: Bytes SHALL be sent in ascending byte order, starting with bits [7:0].
- Each byte is framed as: start bit 0, then DATA_WIDTH data bits LSB first, then stop bit 1.
REQ-019: tx SHALL be registered, and every bit SHALL hold for exactly CLKS_PER_BIT cycles, timed by a baud counter that restarts at every bit boundary.
REQ-020: With acceptance at edge T, tx and busy_sender_data SHALL both go to 0/1 respectively at T+1.
REQ-021: Transitions:
- START -> DATA after one bit time.
- DATA -> STOP after DATA_WIDTH bit times.
- STOP -> START while the byte index < latched size-1 (incrementing the index); no idle gap is allowed between bytes.
- STOP -> IDLE otherwise.
REQ-022: busy_sender_data SHALL stay high for exactly size*10*CLKS_PER_BIT cycles.
REQ-023: line_done SHALL be high only in the first cycle where busy_sender_data is 0 again.
REQ-024: While busy, changes to send_data_register, size_line or valid_data SHALL NOT affect the line in flight.
- valid_data=0 during a transfer still sets armed.
REQ-025: A new line SHALL be accepted in the first IDLE cycle (the line_done cycle) if valid_data=1 and armed=1.
- With back-to-back requests, tx therefore stays high for exactly one cycle between lines.
REQ-026: The byte counter (SIZE_WORD bits), bit counter and baud counter SHALL never wrap during a line; each counter's terminal value is its exit condition.

Reset
REQ-027: On rst=1 at an edge, regardless of state, the block SHALL apply these values on the next cycle:
- state=IDLE, tx=1, busy_sender_data=0, line_done=0, armed=0, and all counters 0.
REQ-028: A frame interrupted by rst SHALL NOT resume.
- The first request after reset needs valid_data low for at least one cycle, then high.

Verification (CLKS_PER_BIT=4)
REQ-029: Single-line check:
- Stimulus: send_data_register=32'h0D595342, size_line=4, valid_data pulsed for one cycle.
- Required: tx carries 0x42, 0x53, 0x59, 0x0D, each as start/LSB-first/stop; busy_sender_data is high for exactly 160 cycles; line_done pulses once.
REQ-030: Held-level check:
- Stimulus: valid_data held high for 500 cycles with 32'h0D0A4B4F, size 4.
- Required: exactly one line "OK\r\n" (0x4F, 0x4B, 0x0A, 0x0D) is sent, and no second transmission occurs until valid_data falls and rises again.
REQ-031: Size-boundary check:
- size_line=0 -> tx stays 1 and busy_sender_data stays 0.
- size_line=7 -> exactly 4 bytes are sent (160 busy cycles).
- size_line=1 with 32'hxxxxxx30 -> one byte 0x30 is sent (40 busy cycles).
REQ-032: Reset mid-byte check:
- Stimulus: rst asserted during a DATA bit of byte 2.
- Required: next cycle tx=1 and busy_sender_data=0, no line_done pulse, and no transmission while valid_data stays high after reset.
REQ-033: Back-to-back check:
- Stimulus: valid_data dropped mid-line and raised again at line end with 32'h0D0A2031.
- Required: the second line starts in the line_done cycle, and tx has exactly one idle-high cycle between the stop bit and the next start bit.
REQ-034: Mid-flight input change check:
- Stimulus: send_data_register and size_line changed during byte 1.
- Required: the transmitted bytes match the values latched at acceptance.

Source files
------------

// File: rtl/line_sender.sv
// line_sender
// -----------------------------------------------------------------------------
// Sends a line of up to WORD_SIZE/DATA_WIDTH characters over an 8N1 UART
// transmitter. The controller presents the line and its byte count, then
// raises valid_data. Characters go out lowest byte first. Each character is
// framed as a start bit, DATA_WIDTH data bits LSB first, and a stop bit.
// Consecutive characters follow each other with no idle gap.
//
// A request is accepted only after valid_data has been seen low at least
// once. A controller that holds valid_data high therefore gets exactly one
// line. Requests with a byte count of zero are dropped. Counts larger than the
// word holds are clamped to the word's capacity.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous, active-high reset
//   send_data_register  line to transmit, byte 0 in [DATA_WIDTH-1:0]
//   size_line           number of bytes to transmit
//   valid_data          request strobe / level from the controller
//   busy_sender_data    high while a line is in flight
//   tx                  registered UART serial output, idle high
//   line_done           one-cycle pulse in the first idle cycle after a line
// -----------------------------------------------------------------------------
module line_sender #(
  parameter int WORD_SIZE    = 32,
  parameter int SIZE_WORD    = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] send_data_register,
  input  logic [SIZE_WORD-1:0] size_line,
  input  logic                 valid_data,
  output logic                 busy_sender_data,
  output logic                 tx,
  output logic                 line_done
);

  localparam int MAX_BYTES = WORD_SIZE / DATA_WIDTH;
  localparam int BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]     BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [SIZE_WORD-1:0] SIZE_MAX  = SIZE_WORD'(MAX_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic                   tx_next;
  logic                   line_done_next;
  logic                   armed, armed_next;
  logic [BAUD_W-1:0]      baud_cnt, baud_next;
  logic [BIT_W-1:0]       bit_cnt, bit_next;
  logic [SIZE_WORD-1:0]   byte_cnt, byte_next;
  logic [WORD_SIZE-1:0]   line_reg, line_next;
  logic [SIZE_WORD-1:0]   size_reg, size_next;

  logic [DATA_WIDTH-1:0]  cur_byte;
  logic                   baud_end;
  int                     byte_base;

  assign busy_sender_data = (state != IDLE);

  // Select the character being sent and flag the last cycle of a bit period.
  // Every bit boundary restarts the baud counter, so its terminal value always
  // marks the end of the current bit.
  always_comb begin
    byte_base = int'(byte_cnt) * DATA_WIDTH;
    cur_byte  = line_reg[byte_base +: DATA_WIDTH];
    baud_end  = (baud_cnt == BAUD_LAST);
  end

  // Next-state logic. tx is computed one cycle ahead so the output itself is
  // a flop. The first bit of each character appears on the same edge as the
  // state change. armed is set by any low cycle of valid_data. This is true
  // even mid-line, so a controller can re-arm while a line is still in flight
  // and be accepted in the line_done cycle.
  always_comb begin
    state_next     = state;
    tx_next        = tx;
    line_done_next = 1'b0;
    armed_next     = armed;
    baud_next      = baud_cnt;
    bit_next       = bit_cnt;
    byte_next      = byte_cnt;
    line_next      = line_reg;
    size_next      = size_reg;

    if (!valid_data) begin
      armed_next = 1'b1;
    end

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (valid_data && armed) begin
          // A zero-length request consumes the arm without sending anything.
          armed_next = 1'b0;
          if (size_line != '0) begin
            state_next = START;
            tx_next    = 1'b0;
            baud_next  = '0;
            bit_next   = '0;
            byte_next  = '0;
            line_next  = send_data_register;
            size_next  = (size_line > SIZE_MAX) ? SIZE_MAX : size_line;
          end
        end
      end

      START: begin
        if (baud_end) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = cur_byte[0];
        end else begin
          baud_next  = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (baud_end) begin
          baud_next = '0;
          if (bit_cnt == BIT_LAST) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next   = bit_cnt + 1'b1;
            tx_next    = cur_byte[bit_next];
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      STOP: begin
        if (baud_end) begin
          baud_next = '0;
          if (byte_cnt < size_reg - 1'b1) begin
            state_next = START;
            byte_next  = byte_cnt + 1'b1;
            tx_next    = 1'b0;
          end else begin
            state_next     = IDLE;
            tx_next        = 1'b1;
            line_done_next = 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // State and datapath registers. Reset abandons any frame in progress and
  // disarms the request logic. A level still held high after reset therefore
  // cannot start a line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      line_done <= 1'b0;
      armed     <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      line_reg  <= '0;
      size_reg  <= '0;
    end else begin
      state     <= state_next;
      tx        <= tx_next;
      line_done <= line_done_next;
      armed     <= armed_next;
      baud_cnt  <= baud_next;
      bit_cnt   <= bit_next;
      byte_cnt  <= byte_next;
      line_reg  <= line_next;
      size_reg  <= size_next;
    end
  end

endmodule

// File: tb/tb_line_sender.sv
// tb_line_sender
// -----------------------------------------------------------------------------
// Bench for line_sender with CLKS_PER_BIT=4. Each scenario pushes the bytes it
// expects on the wire into byte_q. It also pushes the expected busy duration
// of each line into len_q. Two monitors decode the tx line and measure busy
// runs, then pop and compare against those queues.
// -----------------------------------------------------------------------------
module tb_line_sender;

  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic [31:0] send_data_register;
  logic [2:0]  size_line;
  logic        valid_data;
  logic        busy_sender_data;
  logic        tx;
  logic        line_done;

  logic [7:0]  byte_q[$];
  int          len_q[$];
  int          checks;
  int          passes;
  bit          mon_en;

  line_sender #(
    .WORD_SIZE   (32),
    .SIZE_WORD   (3),
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .send_data_register(send_data_register),
    .size_line         (size_line),
    .valid_data        (valid_data),
    .busy_sender_data  (busy_sender_data),
    .tx                (tx),
    .line_done         (line_done)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never settles.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    else
      passes++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a line is its word cut into bytes lowest-first, clamped
  // to four bytes. Each byte takes ten bit times.
  task automatic expectLine(input logic [31:0] word, input int size);
    int n;
    n = (size > 4) ? 4 : size;
    for (int i = 0; i < n; i++)
      byte_q.push_back(8'((word >> (8 * i)) & 32'hFF));
    if (n > 0)
      len_q.push_back(n * 10 * CPB);
  endtask

  task automatic applyStimulus(input logic [31:0] word, input int size, input int hold);
    send_data_register = word;
    size_line          = 3'(size);
    valid_data         = 1'b1;
    repeat (hold) tick();
    valid_data = 1'b0;
    tick();
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (n < budget &&
           !(busy_sender_data === 1'b0 && byte_q.size() == 0 && len_q.size() == 0)) begin
      tick();
      n++;
    end
    checkOutput("idle_within_budget", 32'(n < budget), 32'd1);
  endtask

  // UART monitor: on a falling tx edge, capture one full frame of samples.
  // It checks that every bit is held for CPB cycles, then decodes the byte.
  // A reset seen during the frame discards it.
  initial begin : frame_monitor
    logic       prev_tx;
    logic       frame[10*CPB];
    logic [7:0] got;
    logic       ok;
    bit         aborted;
    wait (mon_en);
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        prev_tx = 1'b1;
      end else if (prev_tx === 1'b1 && tx === 1'b0) begin
        aborted  = 1'b0;
        frame[0] = tx;
        for (int i = 1; i < 10 * CPB && !aborted; i++) begin
          @(negedge clk);
          if (rst === 1'b1) aborted = 1'b1;
          frame[i] = tx;
        end
        if (!aborted) begin
          ok = 1'b1;
          for (int b = 0; b < 10; b++)
            for (int k = 1; k < CPB; k++)
              if (frame[b*CPB+k] !== frame[b*CPB]) ok = 1'b0;
          if (frame[0] !== 1'b0 || frame[9*CPB] !== 1'b1) ok = 1'b0;
          for (int b = 0; b < 8; b++) got[b] = frame[(b+1)*CPB];
          checkOutput("frame_shape", 32'(ok), 32'd1);
          checkOutput("byte_was_expected", 32'(byte_q.size() != 0), 32'd1);
          if (byte_q.size() != 0)
            checkOutput("tx_byte", 32'(got), 32'(byte_q.pop_front()));
        end
        prev_tx = tx;
      end else begin
        prev_tx = tx;
      end
    end
  end

  // Busy monitor: measures each busy run. At the end of a run it checks the
  // run length and requires line_done in that first idle cycle, unless the
  // run was cut short by reset. line_done seen anywhere else is reported.
  initial begin : busy_monitor
    int   run;
    logic prev_busy;
    logic prev_rst;
    wait (mon_en);
    run       = 0;
    prev_busy = 1'b0;
    prev_rst  = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_sender_data === 1'b1) run++;
      if (prev_busy === 1'b1 && busy_sender_data === 1'b0) begin
        if (prev_rst === 1'b1) begin
          checkOutput("reset_no_line_done", 32'(line_done), 32'd0);
        end else begin
          checkOutput("line_done_at_end", 32'(line_done), 32'd1);
          checkOutput("busy_run_was_expected", 32'(len_q.size() != 0), 32'd1);
          if (len_q.size() != 0)
            checkOutput("busy_length", 32'(run), 32'(len_q.pop_front()));
        end
        run = 0;
      end else if (line_done !== 1'b0) begin
        checkOutput("line_done_spurious", 32'(line_done), 32'd0);
      end
      prev_busy = busy_sender_data;
      prev_rst  = rst;
    end
  end

  // Scenario sequence.
  initial begin : stimulus
    logic [31:0] w;
    logic [31:0] w2;
    int          s;
    int          cnt_busy;
    int          cnt_low;
    int          n;

    checks             = 0;
    passes             = 0;
    mon_en             = 1'b0;
    rst                = 1'b1;
    valid_data         = 1'b0;
    send_data_register = '0;
    size_line          = '0;

    // Reset state.
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_busy", 32'(busy_sender_data), 32'd0);
    checkOutput("reset_line_done", 32'(line_done), 32'd0);
    mon_en = 1'b1;
    repeat (2) tick();

    // Single four-byte line from a one-cycle pulse.
    $display("[TB] single line");
    expectLine(32'h0D595342, 4);
    applyStimulus(32'h0D595342, 4, 1);
    waitIdle(1000);
    tick();

    // Level held for 500 cycles gives one line. A fall and rise gives another.
    $display("[TB] held level");
    expectLine(32'h0D0A4B4F, 4);
    applyStimulus(32'h0D0A4B4F, 4, 500);
    checkOutput("held_no_retrigger", 32'(busy_sender_data), 32'd0);
    expectLine(32'h0D0A4B4F, 4);
    applyStimulus(32'h0D0A4B4F, 4, 1);
    waitIdle(1000);
    tick();

    // Size zero is dropped and disarms, so a later non-zero size under the
    // same held level still sends nothing.
    $display("[TB] size zero");
    send_data_register = 32'h12345678;
    size_line          = 3'd0;
    valid_data         = 1'b1;
    cnt_busy = 0;
    cnt_low  = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 2) size_line = 3'd4;
      if (busy_sender_data !== 1'b0) cnt_busy++;
      if (tx !== 1'b1) cnt_low++;
    end
    valid_data = 1'b0;
    tick();
    checkOutput("size0_busy_cycles", 32'(cnt_busy), 32'd0);
    checkOutput("size0_tx_low_cycles", 32'(cnt_low), 32'd0);

    // Oversized count is clamped to four bytes.
    $display("[TB] size seven");
    w = $urandom;
    expectLine(w, 7);
    applyStimulus(w, 7, 1);
    waitIdle(1000);
    tick();

    // Single byte: only the low byte of the word matters.
    $display("[TB] size one");
    w = {24'($urandom), 8'h30};
    expectLine(w, 1);
    applyStimulus(w, 1, 1);
    waitIdle(1000);
    tick();

    // Reset while byte 2 is in its data bits. Only bytes 0 and 1 complete.
    $display("[TB] reset mid-byte");
    w = $urandom;
    byte_q.push_back(w[7:0]);
    byte_q.push_back(w[15:8]);
    send_data_register = w;
    size_line          = 3'd4;
    valid_data         = 1'b1;
    tick();
    repeat (94) tick();
    rst = 1'b1;
    tick();
    checkOutput("midreset_tx", 32'(tx), 32'd1);
    checkOutput("midreset_busy", 32'(busy_sender_data), 32'd0);
    checkOutput("midreset_line_done", 32'(line_done), 32'd0);
    rst      = 1'b0;
    cnt_busy = 0;
    repeat (100) begin
      tick();
      if (busy_sender_data !== 1'b0) cnt_busy++;
    end
    checkOutput("after_reset_no_start", 32'(cnt_busy), 32'd0);
    valid_data = 1'b0;
    tick();
    checkOutput("midreset_bytes_drained", 32'(byte_q.size()), 32'd0);

    // Back-to-back lines. The controller drops valid mid-line and raises it
    // again before the end, so the next line starts in the line_done cycle.
    $display("[TB] back to back");
    w  = 32'h0D0A2031;
    w2 = $urandom;
    s  = int'($urandom_range(1, 4));
    expectLine(w, 4);
    expectLine(w2, s);
    send_data_register = w;
    size_line          = 3'd4;
    valid_data         = 1'b1;
    repeat (40) tick();
    valid_data = 1'b0;
    repeat (20) tick();
    send_data_register = w2;
    size_line          = 3'(s);
    valid_data         = 1'b1;
    n = 0;
    while (line_done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checkOutput("b2b_line_done_seen", 32'(n < 400), 32'd1);
    checkOutput("b2b_gap_tx_high", 32'(tx), 32'd1);
    checkOutput("b2b_gap_not_busy", 32'(busy_sender_data), 32'd0);
    tick();
    checkOutput("b2b_restart_busy", 32'(busy_sender_data), 32'd1);
    checkOutput("b2b_restart_start_bit", 32'(tx), 32'd0);
    valid_data = 1'b0;
    tick();
    waitIdle(1000);
    tick();

    // Inputs change during byte 1 but must not disturb the latched line.
    $display("[TB] mid-flight change");
    w = $urandom;
    expectLine(w, 4);
    applyStimulus(w, 4, 1);
    repeat (50) tick();
    send_data_register = ~w;
    size_line          = 3'd1;
    waitIdle(1000);
    tick();

    // Randomised lines with random sizes and random hold lengths.
    $display("[TB] random lines");
    for (int i = 0; i < 12; i++) begin
      w = $urandom;
      s = int'($urandom_range(0, 7));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 300)) : 1;
      expectLine(w, s);
      applyStimulus(w, s, n);
      waitIdle(2000);
      tick();
    end

    repeat (50) tick();
    checkOutput("queues_drained", 32'(byte_q.size() + len_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
